// File: rtl/crono_ajuste_ctrl.sv
// Adjust-path front end: button conditioning, field select
// and single-cycle up/down pulses with auto-repeat.
module crono_ajuste_ctrl #(
  parameter int DEB_CYCLES = 20,
  parameter int REP_DELAY  = 500,
  parameter int REP_RATE   = 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_next,
  input  logic       btn_prev,
  input  logic       adj_mode,
  output logic [1:0] EN,
  output logic       aumento,
  output logic       disminuye
);

  localparam logic [15:0] DebLast  = 16'(DEB_CYCLES - 1);
  localparam logic [15:0] DlyLast  = 16'(REP_DELAY - 1);
  localparam logic [15:0] RateLast = 16'(REP_RATE - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DELAY,
    S_REPEAT
  } state_e;

  // bit order: 0 up, 1 down, 2 next, 3 prev
  logic [3:0]  raw;
  logic [3:0]  sync1_q;
  logic [3:0]  sync2_q;
  logic [3:0]  deb_q;
  logic [3:0]  deb_d;
  logic [3:0]  debp_q;
  logic [3:0]  press;
  logic [15:0] dcnt_q [4];
  logic [15:0] dcnt_d [4];

  assign raw = {btn_prev, btn_next, btn_down, btn_up};

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      deb_d[i]  = deb_q[i];
      dcnt_d[i] = '0;
      if (sync2_q[i] != deb_q[i]) begin
        if (dcnt_q[i] == DebLast) begin
          deb_d[i] = ~deb_q[i];
        end else begin
          dcnt_d[i] = dcnt_q[i] + 16'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      deb_q   <= '0;
      debp_q  <= '0;
      for (int i = 0; i < 4; i++) begin
        dcnt_q[i] <= '0;
      end
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      debp_q  <= deb_q;
      for (int i = 0; i < 4; i++) begin
        dcnt_q[i] <= dcnt_d[i];
      end
    end
  end

  assign press = deb_q & ~debp_q;

  logic up_p;
  logic dn_p;
  logic nx_p;
  logic pv_p;
  logic up_l;
  logic dn_l;

  assign up_p = press[0];
  assign dn_p = press[1];
  assign nx_p = press[2];
  assign pv_p = press[3];
  // levels as they stand after this edge, so a
  // releasing button never gets one last pulse
  assign up_l = deb_d[0];
  assign dn_l = deb_d[1];

  logic [1:0] en_q;
  logic [1:0] en_d;
  logic       adj_q;

  always_comb begin
    en_d = en_q;
    if (!adj_mode) begin
      en_d = 2'd3;
    end else if (!adj_q || en_q == 2'd3) begin
      en_d = 2'd0;
    end else if (nx_p && !pv_p) begin
      en_d = (en_q == 2'd2) ? 2'd0 : en_q + 2'd1;
    end else if (pv_p && !nx_p) begin
      en_d = (en_q == 2'd0) ? 2'd2 : en_q - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      en_q  <= 2'd3;
      adj_q <= 1'b0;
    end else begin
      en_q  <= en_d;
      adj_q <= adj_mode;
    end
  end

  state_e      st_q;
  logic        dir_q;
  logic [15:0] rcnt_q;
  logic        aum_q;
  logic        dis_q;
  logic        held;
  logic        opp;
  logic        rlast;

  assign held  = dir_q ? dn_l : up_l;
  assign opp   = dir_q ? up_l : dn_l;
  assign rlast = (st_q == S_DELAY) ? (rcnt_q == DlyLast)
                                   : (rcnt_q == RateLast);

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q   <= S_IDLE;
      dir_q  <= 1'b0;
      rcnt_q <= '0;
      aum_q  <= 1'b0;
      dis_q  <= 1'b0;
    end else begin
      aum_q <= 1'b0;
      dis_q <= 1'b0;
      unique case (st_q)
        S_IDLE: begin
          rcnt_q <= '0;
          if (adj_mode && up_p && !dn_l) begin
            dir_q <= 1'b0;
            aum_q <= 1'b1;
            st_q  <= S_DELAY;
          end else if (adj_mode && dn_p && !up_l) begin
            dir_q <= 1'b1;
            dis_q <= 1'b1;
            st_q  <= S_DELAY;
          end
        end
        S_DELAY, S_REPEAT: begin
          if (!adj_mode || !held || opp) begin
            st_q   <= S_IDLE;
            rcnt_q <= '0;
          end else if (rlast) begin
            st_q   <= S_REPEAT;
            rcnt_q <= '0;
            aum_q  <= ~dir_q;
            dis_q  <= dir_q;
          end else begin
            rcnt_q <= rcnt_q + 16'd1;
          end
        end
        default: begin
          st_q   <= S_IDLE;
          rcnt_q <= '0;
        end
      endcase
    end
  end

  assign EN        = en_q;
  assign aumento   = aum_q;
  assign disminuye = dis_q;

endmodule
